// File: rtl/updi_pkg.sv
// Shared UPDI framing definitions: FSM states, frame geometry, line levels and parity.
package updi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } updi_state_t;

   localparam int UPDI_FRAME_BITS = 12;
   localparam int UPDI_DATA_BITS  = 8;
   localparam int UPDI_STOP_BITS  = 2;

   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   // Even parity over the data byte; the receive-side checker uses the same function.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/updi_frame_tx_if.sv
// Byte / break request handshake between a UPDI host controller and the transmit framer.
interface updi_frame_tx_if;
   import updi_pkg::*;

   logic [UPDI_DATA_BITS-1:0] data_in;
   logic                      valid_in;
   logic                      ready_out;
   logic                      send_break;

   modport master (
      output data_in,
      output valid_in,
      output send_break,
      input  ready_out
   );

   modport slave (
      input  data_in,
      input  valid_in,
      input  send_break,
      output ready_out
   );

endinterface

// File: rtl/updi_bit_timer.sv
// Bit-period down-counter: bit_end strobes on the last cycle of every CLK_DIV-cycle bit while enabled.
module updi_bit_timer #(
   parameter int CLK_DIV   = 16,
   parameter int DIV_WIDTH = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic enable,
   output logic bit_end
);

   localparam logic [DIV_WIDTH-1:0] RELOAD = DIV_WIDTH'(CLK_DIV - 1);

   logic [DIV_WIDTH-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= RELOAD;
      end else if (enable) begin
         cnt <= (cnt == '0) ? RELOAD : cnt - DIV_WIDTH'(1);
      end
   end

   assign bit_end = enable && !start && (cnt == '0);

endmodule

// File: rtl/updi_frame_tx.sv
// UPDI transmit framer: serialises bytes as start/8 data/even parity/2 stop frames and generates BREAK.
//
// state  | meaning
// IDLE   | line released, ready for a byte or a break request
// START  | driving the start bit (low)
// DATA   | shifting out data bits LSB first
// PARITY | driving the latched even parity bit
// STOP   | two high stop bits, then one released cycle before IDLE
// BREAK  | line held low for BREAK_BITS bit-times, then one released cycle
module updi_frame_tx
   import updi_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int DIV_WIDTH  = 16,
   parameter int BREAK_BITS = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   updi_frame_tx_if.slave        bus,
   output logic                  tx_out,
   output logic                  tx_oe,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  break_done
);

   localparam logic [2:0] BIT_LAST  = 3'(UPDI_DATA_BITS - 1);
   localparam logic       STOP_LAST = 1'(UPDI_STOP_BITS - 1);
   localparam logic [4:0] BRK_LAST  = 5'(BREAK_BITS - 1);

   updi_state_t state, state_n;
   logic [7:0]  shift, shift_n;
   logic        par, par_n;
   logic [2:0]  bit_idx, bit_idx_n;
   logic        stop_idx, stop_idx_n;
   logic        tail, tail_n;
   logic [4:0]  brk_cnt, brk_cnt_n;
   logic        tx_out_n, tx_oe_n;
   logic        timer_start;
   logic        timer_en;
   logic        bit_end;

   // The timer idles during the released tail cycle so it cannot strobe there.
   assign timer_en = (state != IDLE) && !tail;

   updi_bit_timer #(
      .CLK_DIV   (CLK_DIV),
      .DIV_WIDTH (DIV_WIDTH)
   ) u_bit_timer (
      .clk     (clk),
      .reset   (reset),
      .start   (timer_start),
      .enable  (timer_en),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         shift    <= '0;
         par      <= 1'b0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         tail     <= 1'b0;
         brk_cnt  <= '0;
         tx_out   <= STOP_LEVEL;
         tx_oe    <= 1'b0;
      end else begin
         state    <= state_n;
         shift    <= shift_n;
         par      <= par_n;
         bit_idx  <= bit_idx_n;
         stop_idx <= stop_idx_n;
         tail     <= tail_n;
         brk_cnt  <= brk_cnt_n;
         tx_out   <= tx_out_n;
         tx_oe    <= tx_oe_n;
      end
   end

   // Line values are computed for the next cycle so tx_out/tx_oe come straight from flops.
   always_comb begin
      state_n     = state;
      shift_n     = shift;
      par_n       = par;
      bit_idx_n   = bit_idx;
      stop_idx_n  = stop_idx;
      tail_n      = tail;
      brk_cnt_n   = brk_cnt;
      tx_out_n    = tx_out;
      tx_oe_n     = tx_oe;
      timer_start = 1'b0;
      frame_done  = 1'b0;
      break_done  = 1'b0;

      unique case (state)
         IDLE: begin
            tx_out_n = STOP_LEVEL;
            tx_oe_n  = 1'b0;
            tail_n   = 1'b0;
            if (bus.send_break) begin
               state_n     = BREAK;
               brk_cnt_n   = '0;
               timer_start = 1'b1;
               tx_out_n    = START_LEVEL;
               tx_oe_n     = 1'b1;
            end else if (bus.valid_in) begin
               state_n     = START;
               shift_n     = bus.data_in;
               par_n       = even_parity(bus.data_in);
               timer_start = 1'b1;
               tx_out_n    = START_LEVEL;
               tx_oe_n     = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_n   = DATA;
               bit_idx_n = '0;
               tx_out_n  = shift[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == BIT_LAST) begin
                  state_n  = PARITY;
                  tx_out_n = par;
               end else begin
                  shift_n   = shift >> 1;
                  bit_idx_n = bit_idx + 3'd1;
                  tx_out_n  = shift[1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_n    = STOP;
               stop_idx_n = 1'b0;
               tx_out_n   = STOP_LEVEL;
            end
         end
         STOP: begin
            if (tail) begin
               state_n = IDLE;
               tail_n  = 1'b0;
            end else if (bit_end) begin
               if (stop_idx == STOP_LAST) begin
                  frame_done = 1'b1;
                  tail_n     = 1'b1;
                  tx_oe_n    = 1'b0;
                  tx_out_n   = STOP_LEVEL;
               end else begin
                  stop_idx_n = 1'b1;
               end
            end
         end
         BREAK: begin
            if (tail) begin
               state_n = IDLE;
               tail_n  = 1'b0;
            end else if (bit_end) begin
               if (brk_cnt == BRK_LAST) begin
                  break_done = 1'b1;
                  tail_n     = 1'b1;
                  tx_oe_n    = 1'b0;
                  tx_out_n   = STOP_LEVEL;
               end else begin
                  brk_cnt_n = brk_cnt + 5'd1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.ready_out = (state == IDLE);
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_updi_frame_tx.sv
// Self-checking bench for updi_frame_tx: a line monitor captures frames, a scoreboard holds expected frames.
module tb_updi_frame_tx;
   import updi_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   updi_frame_tx_if if4 ();
   updi_frame_tx_if if2 ();

   logic tx4, oe4, busy4, fd4, bd4;
   logic tx2, oe2, busy2, fd2, bd2;

   updi_frame_tx #(.CLK_DIV(4), .DIV_WIDTH(16), .BREAK_BITS(12)) u_dut4 (
      .clk(clk), .reset(reset), .bus(if4), .tx_out(tx4), .tx_oe(oe4),
      .busy(busy4), .frame_done(fd4), .break_done(bd4));

   updi_frame_tx #(.CLK_DIV(2), .DIV_WIDTH(16), .BREAK_BITS(12)) u_dut2 (
      .clk(clk), .reset(reset), .bus(if2), .tx_out(tx2), .tx_oe(oe2),
      .busy(busy2), .frame_done(fd2), .break_done(bd2));

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          len;
      logic [11:0] bits;
      logic        widths_ok;
      int          done_pos;
      int          bdone_pos;
      int          gap;
      logic        rdy_bad;
   } run_t;

   typedef struct {
      logic        is_break;
      logic [11:0] bits;
      int          gap;
   } exp_t;

   run_t got_q[$];
   exp_t exp_q[$];

   // Monitor: watches one DUT (sel) and records each contiguous tx_oe=1 run.
   logic sel = 1'b0;
   logic m_tx, m_oe, m_fd, m_bd, m_rdy;
   assign m_tx  = sel ? tx2 : tx4;
   assign m_oe  = sel ? oe2 : oe4;
   assign m_fd  = sel ? fd2 : fd4;
   assign m_bd  = sel ? bd2 : bd4;
   assign m_rdy = sel ? if2.ready_out : if4.ready_out;

   logic samp [0:255];
   int   run_len = 0, gap_cnt = 1000, gap_rec = 0, done_pos = -1, bdone_pos = -1;
   logic in_run = 1'b0, rdy_bad = 1'b0;
   int   fd_total = 0;

   always @(negedge clk) begin
      int   div;
      run_t r;
      div = sel ? 2 : 4;
      if (m_fd) fd_total++;
      if (m_oe) begin
         if (!in_run) begin
            in_run = 1'b1; run_len = 0; gap_rec = gap_cnt;
            done_pos = -1; bdone_pos = -1; rdy_bad = 1'b0;
         end
         if (run_len < 256) samp[run_len] = m_tx;
         if (m_fd) done_pos = run_len;
         if (m_bd) bdone_pos = run_len;
         if (m_rdy) rdy_bad = 1'b1;
         run_len++;
      end else begin
         if (in_run) begin
            r.len = run_len; r.gap = gap_rec; r.done_pos = done_pos;
            r.bdone_pos = bdone_pos; r.rdy_bad = rdy_bad;
            for (int i = 0; i < UPDI_FRAME_BITS; i++)
               r.bits[i] = (i * div < run_len && i * div < 256) ? samp[i * div] : 1'bx;
            r.widths_ok = 1'b1;
            for (int j = 0; j < run_len && j < 256; j++)
               if (samp[j] !== samp[(j / div) * div]) r.widths_ok = 1'b0;
            got_q.push_back(r);
            in_run = 1'b0;
            gap_cnt = 0;
         end
         if (gap_cnt < 1000) gap_cnt++;
      end
   end

   function automatic logic [11:0] model_frame(input logic [7:0] d);
      return {STOP_LEVEL, STOP_LEVEL, ^d, d, START_LEVEL};
   endfunction

   task automatic wait_run(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (got_q.size() > 0) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_ready4(input logic level, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (if4.ready_out === level) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic send4(input logic [7:0] d, output bit ok);
      @(negedge clk);
      if4.data_in  = d;
      if4.valid_in = 1'b1;
      wait_ready4(1'b0, ok);
      if4.valid_in = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_tests++; if (tx4 !== 1'b1) begin n_fail++; $display("FAIL reset_tx_out got %b want 1", tx4); end
      n_tests++; if (oe4 !== 1'b0) begin n_fail++; $display("FAIL reset_tx_oe got %b want 0", oe4); end
      n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy4); end
      n_tests++; if (if4.ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", if4.ready_out); end
      n_tests++; if ({fd4, bd4} !== 2'b00) begin n_fail++; $display("FAIL reset_done got %b want 00", {fd4, bd4}); end
      n_tests++; if ({tx2, oe2} !== 2'b10) begin n_fail++; $display("FAIL reset_div2_line got %b want 10", {tx2, oe2}); end
   endtask

   task automatic test_frame_55;
      bit ok; run_t r; exp_t e;
      send4(8'h55, ok);
      exp_q.push_back('{is_break: 1'b0, bits: 12'b1100_1010_1010, gap: -1});
      wait_run(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL f55_timeout got no frame want one"); return; end
      r = got_q.pop_front(); e = exp_q.pop_front();
      n_tests++; if (r.bits !== e.bits) begin n_fail++; $display("FAIL f55_bits got %b want %b", r.bits, e.bits); end
      n_tests++; if (r.len !== 48) begin n_fail++; $display("FAIL f55_len got %0d want 48", r.len); end
      n_tests++; if (r.done_pos !== 47) begin n_fail++; $display("FAIL f55_done_pos got %0d want 47", r.done_pos); end
      n_tests++; if (r.widths_ok !== 1'b1) begin n_fail++; $display("FAIL f55_bit_width got %b want 1", r.widths_ok); end
   endtask

   task automatic test_parity_01;
      bit ok; run_t r; exp_t e; logic err;
      send4(8'h01, ok);
      exp_q.push_back('{is_break: 1'b0, bits: model_frame(8'h01), gap: -1});
      wait_run(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL p01_timeout got no frame want one"); return; end
      r = got_q.pop_front(); e = exp_q.pop_front();
      n_tests++; if (r.bits !== e.bits) begin n_fail++; $display("FAIL p01_bits got %b want %b", r.bits, e.bits); end
      n_tests++; if (r.bits[9] !== 1'b1) begin n_fail++; $display("FAIL p01_parity got %b want 1", r.bits[9]); end
      err = (r.bits[0] !== 1'b0) || (r.bits[11:10] !== 2'b11) || ((^r.bits[9:1]) !== 1'b0);
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL p01_rx_check got err=%b want 0", err); end
   endtask

   task automatic test_back_to_back;
      bit ok; run_t r; exp_t e;
      @(negedge clk);
      if4.data_in = 8'hA5; if4.valid_in = 1'b1;
      exp_q.push_back('{is_break: 1'b0, bits: model_frame(8'hA5), gap: -1});
      wait_ready4(1'b0, ok);
      if4.data_in = 8'h3C;
      exp_q.push_back('{is_break: 1'b0, bits: model_frame(8'h3C), gap: 2});
      wait_ready4(1'b1, ok);
      wait_ready4(1'b0, ok);
      if4.data_in = 8'hFF; if4.valid_in = 1'b0;
      for (int k = 0; k < 2; k++) begin
         wait_run(ok);
         n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout frame %0d got none want one", k); return; end
         r = got_q.pop_front(); e = exp_q.pop_front();
         n_tests++; if (r.bits !== e.bits) begin n_fail++; $display("FAIL b2b_bits frame %0d got %b want %b", k, r.bits, e.bits); end
         n_tests++; if (r.rdy_bad !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_frame frame %0d got %b want 0", k, r.rdy_bad); end
         if (e.gap >= 0) begin
            n_tests++; if (r.gap !== e.gap) begin n_fail++; $display("FAIL b2b_gap got %0d want %0d", r.gap, e.gap); end
         end
      end
   endtask

   task automatic test_break;
      bit ok; run_t r; exp_t e;
      @(negedge clk);
      if4.data_in = 8'h96; if4.valid_in = 1'b1; if4.send_break = 1'b1;
      exp_q.push_back('{is_break: 1'b1, bits: 12'h000, gap: -1});
      exp_q.push_back('{is_break: 1'b0, bits: model_frame(8'h96), gap: 2});
      wait_ready4(1'b0, ok);
      if4.send_break = 1'b0;
      wait_ready4(1'b1, ok);
      wait_ready4(1'b0, ok);
      if4.valid_in = 1'b0;
      wait_run(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL brk_timeout got no break want one"); return; end
      r = got_q.pop_front(); e = exp_q.pop_front();
      n_tests++; if (r.len !== 48) begin n_fail++; $display("FAIL brk_len got %0d want 48", r.len); end
      n_tests++; if (r.bits !== e.bits || r.widths_ok !== 1'b1) begin n_fail++; $display("FAIL brk_low got %b/%b want %b/1", r.bits, r.widths_ok, e.bits); end
      n_tests++; if (r.bdone_pos !== 47 || r.done_pos !== -1) begin n_fail++; $display("FAIL brk_done got %0d/%0d want 47/-1", r.bdone_pos, r.done_pos); end
      n_tests++; if (r.rdy_bad !== 1'b0) begin n_fail++; $display("FAIL brk_ready got %b want 0", r.rdy_bad); end
      wait_run(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL brk_byte_timeout got no frame want one"); return; end
      r = got_q.pop_front(); e = exp_q.pop_front();
      n_tests++; if (r.bits !== e.bits) begin n_fail++; $display("FAIL brk_byte_bits got %b want %b", r.bits, e.bits); end
      n_tests++; if (r.gap !== e.gap) begin n_fail++; $display("FAIL brk_byte_gap got %0d want %0d", r.gap, e.gap); end
   endtask

   task automatic test_reset_mid;
      bit ok; run_t r; exp_t e; int fd_before;
      fd_before = fd_total;
      send4(8'hC3, ok);
      repeat (10) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      n_tests++; if ({tx4, oe4} !== 2'b10) begin n_fail++; $display("FAIL rst_mid_line got %b want 10", {tx4, oe4}); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_tests++; if (if4.ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b want 1", if4.ready_out); end
      n_tests++; if (fd_total !== fd_before) begin n_fail++; $display("FAIL rst_mid_no_done got %0d want %0d", fd_total, fd_before); end
      got_q.delete();
      send4(8'h5A, ok);
      exp_q.push_back('{is_break: 1'b0, bits: model_frame(8'h5A), gap: -1});
      wait_run(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_mid_next_timeout got no frame want one"); return; end
      r = got_q.pop_front(); e = exp_q.pop_front();
      n_tests++; if (r.bits !== e.bits || r.len !== 48) begin n_fail++; $display("FAIL rst_mid_next got %b/%0d want %b/48", r.bits, r.len, e.bits); end
   endtask

   task automatic test_div2;
      bit ok; run_t r; exp_t e;
      @(negedge clk);
      sel = 1'b1;
      @(negedge clk);
      if2.data_in = 8'hFF; if2.valid_in = 1'b1;
      exp_q.push_back('{is_break: 1'b0, bits: model_frame(8'hFF), gap: -1});
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (if2.ready_out === 1'b0) ok = 1'b1;
      end
      if2.valid_in = 1'b0;
      wait_run(ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL div2_timeout got no frame want one"); return; end
      r = got_q.pop_front(); e = exp_q.pop_front();
      n_tests++; if (r.bits !== e.bits) begin n_fail++; $display("FAIL div2_bits got %b want %b", r.bits, e.bits); end
      n_tests++; if (r.len !== 24) begin n_fail++; $display("FAIL div2_len got %0d want 24", r.len); end
      n_tests++; if (r.widths_ok !== 1'b1) begin n_fail++; $display("FAIL div2_bit_width got %b want 1", r.widths_ok); end
      n_tests++; if (r.done_pos !== 23) begin n_fail++; $display("FAIL div2_done_pos got %0d want 23", r.done_pos); end
   endtask

   initial begin
      if4.data_in = 8'h00; if4.valid_in = 1'b0; if4.send_break = 1'b0;
      if2.data_in = 8'h00; if2.valid_in = 1'b0; if2.send_break = 1'b0;
      test_reset();
      test_frame_55();
      test_parity_01();
      test_back_to_back();
      test_break();
      test_reset_mid();
      test_div2();
      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got no finish want finish before time limit");
      $fatal(1);
   end

endmodule
